// File: rtl/mac_engine_vec_if.sv
// Stream and control bundle for mac_engine_vec: a/b/c operand sinks, d result source,
// plus the control word and status flags exchanged with the HWPE control FSM.
interface mac_engine_vec_if #(
  parameter int unsigned DW      = 16,
  parameter int unsigned NLANES  = 4,
  parameter int unsigned MAX_LEN = 1024
);
  localparam int unsigned CW    = $clog2(MAX_LEN) + 1;
  localparam int unsigned ACC_W = 2 * DW + $clog2(MAX_LEN);
  localparam int unsigned SW    = $clog2(ACC_W);
  localparam int unsigned BW    = DW * NLANES;

  typedef struct packed {
    logic          clear;
    logic          enable;
    logic          start;
    logic          mode;
    logic          use_c;
    logic          round;
    logic          sat;
    logic [SW-1:0] shift;
    logic [CW-1:0] len;
  } ctrl_t;

  typedef struct packed {
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          acc_valid;
    logic          done;
  } flags_t;

  logic [BW-1:0]   a_data;
  logic            a_valid;
  logic            a_ready;
  logic [BW-1:0]   b_data;
  logic            b_valid;
  logic            b_ready;
  logic [BW-1:0]   c_data;
  logic            c_valid;
  logic            c_ready;
  logic [BW-1:0]   d_data;
  logic [BW/8-1:0] d_strb;
  logic            d_valid;
  logic            d_ready;
  ctrl_t           ctrl;
  flags_t          flags;

  modport master (
    output a_data, a_valid, b_data, b_valid, c_data, c_valid, d_ready, ctrl,
    input  a_ready, b_ready, c_ready, d_data, d_strb, d_valid, flags
  );

  modport slave (
    input  a_data, a_valid, b_data, b_valid, c_data, c_valid, d_ready, ctrl,
    output a_ready, b_ready, c_ready, d_data, d_strb, d_valid, flags
  );
endinterface

// File: rtl/mac_engine_vec.sv
// NLANES-wide multiply / dot-product engine: joined a*b multiplier stage feeding either the
// d stream directly (MUL) or a per-lane accumulator sequenced by IDLE/LOAD/ACC/OUT (DOT).
module mac_engine_vec #(
  parameter int unsigned DW      = 16,
  parameter int unsigned NLANES  = 4,
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           test_mode_i,
  mac_engine_vec_if.slave bus
);
  localparam int unsigned CW    = $clog2(MAX_LEN) + 1;
  localparam int unsigned ACC_W = 2 * DW + $clog2(MAX_LEN);
  localparam int unsigned SW    = $clog2(ACC_W);
  localparam int unsigned MW    = 2 * DW;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ACC = 2'd2, OUT = 2'd3} state_e;

  state_e                        r_state;
  logic [NLANES-1:0][MW-1:0]     r_mult;
  logic                          r_mult_valid;
  logic [NLANES-1:0][ACC_W-1:0]  r_acc;
  logic [CW-1:0]                 r_cnt;
  logic [CW-1:0]                 r_issued;
  logic                          r_acc_valid;
  logic                          r_done;

  logic                          w_en, w_dot, w_issue_ok, w_mult_ready;
  logic                          w_ab_hs, w_c_hs, w_acc_take, w_out_valid, w_d_hs;
  logic [CW-1:0]                 w_cnt_nxt;
  logic [NLANES-1:0][MW-1:0]     w_prod;
  logic [NLANES-1:0][ACC_W-1:0]  w_cshift;
  logic [DW*NLANES-1:0]          w_d_data;
  logic                          w_unused_test_mode;

  assign w_unused_test_mode = test_mode_i;

  // Round-half-up, arithmetic shift, then saturate or truncate to DW bits.
  function automatic logic [DW-1:0] f_conv(input logic [ACC_W-1:0] src, input logic [SW-1:0] sh,
                                           input logic rnd, input logic sat);
    logic signed [ACC_W:0] x, y, half;
    half = '0;
    if (rnd && (sh != '0)) half = (ACC_W+1)'(1) << (sh - SW'(1));
    x = $signed({src[ACC_W-1], src}) + half;
    y = x >>> sh;
    f_conv = y[DW-1:0];
    if (sat && (y > SAT_MAX)) f_conv = SAT_MAX[DW-1:0];
    if (sat && (y < SAT_MIN)) f_conv = SAT_MIN[DW-1:0];
  endfunction

  assign w_en         = bus.ctrl.enable & ~bus.ctrl.clear;
  assign w_dot        = bus.ctrl.mode;
  assign w_issue_ok   = w_dot ? ((r_state == ACC) && (r_issued < bus.ctrl.len)) : 1'b1;
  assign w_acc_take   = w_dot & r_mult_valid & (r_state == ACC);
  assign w_mult_ready = w_dot ? (~r_mult_valid | (r_state == ACC)) : (bus.d_ready | ~r_mult_valid);
  assign w_ab_hs      = w_en & bus.a_valid & bus.b_valid & w_mult_ready & w_issue_ok;
  assign w_c_hs       = bus.c_ready & bus.c_valid;
  assign w_out_valid  = w_en & (w_dot ? (r_state == OUT) : r_mult_valid);
  assign w_d_hs       = w_out_valid & bus.d_ready;
  assign w_cnt_nxt    = r_cnt + CW'(w_acc_take);

  assign bus.a_ready  = w_ab_hs;
  assign bus.b_ready  = w_ab_hs;
  assign bus.c_ready  = w_en & (r_state == LOAD);
  assign bus.d_valid  = w_out_valid;
  assign bus.d_data   = w_out_valid ? w_d_data : '0;
  assign bus.d_strb   = '1;

  assign bus.flags.state     = r_state;
  assign bus.flags.cnt       = r_cnt;
  assign bus.flags.acc_valid = r_acc_valid;
  assign bus.flags.done      = r_done;

  always_comb begin
    w_prod   = '0;
    w_cshift = '0;
    w_d_data = '0;
    for (int k = 0; k < NLANES; k++) begin
      w_prod[k] = $signed({{DW{bus.a_data[k*DW+DW-1]}}, bus.a_data[k*DW +: DW]}) *
                  $signed({{DW{bus.b_data[k*DW+DW-1]}}, bus.b_data[k*DW +: DW]});
      w_cshift[k] = {{(ACC_W-DW){bus.c_data[k*DW+DW-1]}}, bus.c_data[k*DW +: DW]} << bus.ctrl.shift;
      w_d_data[k*DW +: DW] = f_conv(w_dot ? r_acc[k] : {{(ACC_W-MW){r_mult[k][MW-1]}}, r_mult[k]},
                                    bus.ctrl.shift, bus.ctrl.round, bus.ctrl.sat);
    end
  end

  // Multiplier stage, accumulator and DOT sequencing; clear beats enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE; r_mult <= '0; r_mult_valid <= 1'b0; r_acc <= '0;
      r_cnt <= '0; r_issued <= '0; r_acc_valid <= 1'b0; r_done <= 1'b0;
    end else if (bus.ctrl.clear) begin
      r_state <= IDLE; r_mult <= '0; r_mult_valid <= 1'b0; r_acc <= '0;
      r_cnt <= '0; r_issued <= '0; r_acc_valid <= 1'b0; r_done <= 1'b0;
    end else if (bus.ctrl.enable) begin
      r_done <= 1'b0;
      if (w_ab_hs) begin
        r_mult       <= w_prod;
        r_mult_valid <= 1'b1;
      end else if (w_acc_take || (!w_dot && w_d_hs)) begin
        r_mult_valid <= 1'b0;
      end
      case (r_state)
        IDLE: if (bus.ctrl.start && w_dot) begin
          r_cnt    <= '0;
          r_issued <= '0;
          if (bus.ctrl.use_c) begin
            r_state <= LOAD;
          end else begin
            r_acc   <= '0;
            r_state <= ACC;
          end
        end
        LOAD: if (w_c_hs) begin
          r_acc <= w_cshift;
          if (bus.ctrl.len == '0) begin
            r_state     <= OUT;
            r_acc_valid <= 1'b1;
          end else begin
            r_state <= ACC;
          end
        end
        ACC: begin
          if (w_ab_hs) r_issued <= r_issued + CW'(1);
          if (w_acc_take) begin
            for (int k = 0; k < NLANES; k++)
              r_acc[k] <= r_acc[k] + {{(ACC_W-MW){r_mult[k][MW-1]}}, r_mult[k]};
            r_cnt <= w_cnt_nxt;
          end
          if (w_cnt_nxt == bus.ctrl.len) begin
            r_state     <= OUT;
            r_acc_valid <= 1'b1;
          end
        end
        OUT: if (w_d_hs) begin
          r_state     <= IDLE;
          r_acc_valid <= 1'b0;
          r_done      <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Job configuration must hold still while a DOT job is in flight.
  assert property (@(posedge clk_i) disable iff (!rst_ni || bus.ctrl.clear)
    (r_state != IDLE) |-> $stable({bus.ctrl.mode, bus.ctrl.len, bus.ctrl.shift}));

endmodule

// File: tb/tb_mac_engine_vec.sv
// Directed and randomized bench for mac_engine_vec against an integer-arithmetic reference model.
module tb_mac_engine_vec;
  localparam int unsigned DW    = 16;
  localparam int unsigned NL    = 4;
  localparam int unsigned BW    = DW * NL;
  localparam int unsigned ACC_W = 42;
  typedef logic [BW-1:0] beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_mode = 1'b0;
  always #5 clk = ~clk;

  mac_engine_vec_if #(.DW(DW), .NLANES(NL), .MAX_LEN(1024)) bus ();
  mac_engine_vec #(.DW(DW), .NLANES(NL), .MAX_LEN(1024)) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode), .bus(bus)
  );

  beat_t qa[$], qb[$], qc[$], dq[$], expq[$];
  bit    src_on = 1'b1, d_rdy = 1'b1;
  int    n_checks = 0, n_fail = 0, n_ab = 0, n_c = 0, cyc = 0;
  int    last_ab_cyc = -1, first_dv_cyc = -1;
  int    cfg_sh = 0;
  bit    cfg_rnd = 1'b0, cfg_sat = 1'b0;
  logic  o_dv, o_ar, o_cr, o_accv, o_done;
  logic [1:0]  o_state;
  logic [10:0] o_cnt;
  beat_t o_dd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input int l0, input int l1, input int l2, input int l3);
    mk = {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  function automatic beat_t uni(input int v);
    uni = mk(v, v, v, v);
  endfunction

  function automatic longint lane(input beat_t b, input int k);
    logic signed [15:0] s;
    s = b[k*16 +: 16];
    lane = longint'(s);
  endfunction

  function automatic longint wrapacc(input longint v);
    wrapacc = (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
  endfunction

  function automatic logic [15:0] conv(input longint src);
    longint x, y;
    x = src;
    if (cfg_rnd && cfg_sh > 0) x = x + (longint'(1) <<< (cfg_sh - 1));
    y = x >>> cfg_sh;
    if (cfg_sat && y > 32767) return 16'h7FFF;
    if (cfg_sat && y < -32768) return 16'h8000;
    conv = y[15:0];
  endfunction

  function automatic beat_t mul_exp(input beat_t a, input beat_t b);
    for (int k = 0; k < NL; k++) mul_exp[k*16 +: 16] = conv(lane(a, k) * lane(b, k));
  endfunction

  function automatic beat_t dot_exp(input bit uc, input beat_t c, input beat_t ja[$], input beat_t jb[$],
                                    input int first, input int n);
    longint acc;
    for (int k = 0; k < NL; k++) begin
      acc = uc ? wrapacc(lane(c, k) <<< cfg_sh) : 0;
      for (int i = first; i < first + n; i++) acc = wrapacc(acc + lane(ja[i], k) * lane(jb[i], k));
      dot_exp[k*16 +: 16] = conv(acc);
    end
  endfunction

  task automatic drive();
    bus.a_valid = src_on && (qa.size() > 0);
    bus.b_valid = src_on && (qb.size() > 0);
    bus.a_data  = (qa.size() > 0) ? qa[0] : '0;
    bus.b_data  = (qb.size() > 0) ? qb[0] : '0;
    bus.c_valid = (qc.size() > 0);
    bus.c_data  = (qc.size() > 0) ? qc[0] : '0;
    bus.d_ready = d_rdy;
  endtask

  // One clock: observe at the falling edge, then drive fresh inputs just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    o_dv = bus.d_valid; o_dd = bus.d_data; o_ar = bus.a_ready; o_cr = bus.c_ready;
    o_state = bus.flags.state; o_cnt = bus.flags.cnt; o_accv = bus.flags.acc_valid; o_done = bus.flags.done;
    if (o_dv && first_dv_cyc < 0) first_dv_cyc = cyc;
    if (bus.a_valid && bus.b_valid && bus.a_ready) begin
      void'(qa.pop_front()); void'(qb.pop_front());
      n_ab++; last_ab_cyc = cyc;
    end
    if (bus.c_valid && bus.c_ready) begin void'(qc.pop_front()); n_c++; end
    if (bus.d_valid && bus.d_ready) dq.push_back(bus.d_data);
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic set_cfg(input bit md, input bit uc, input bit rnd, input bit st, input int sh, input int ln);
    bus.ctrl.mode = md; bus.ctrl.use_c = uc; bus.ctrl.round = rnd; bus.ctrl.sat = st;
    bus.ctrl.shift = 6'(sh); bus.ctrl.len = 11'(ln);
    cfg_sh = sh; cfg_rnd = rnd; cfg_sat = st;
  endtask

  task automatic push_ab(input beat_t a, input beat_t b);
    qa.push_back(a); qb.push_back(b); drive();
  endtask

  task automatic pulse_start();
    first_dv_cyc = -1;
    bus.ctrl.start = 1'b1;
    cycle();
    bus.ctrl.start = 1'b0;
  endtask

  task automatic wait_dq(input int n, input string tag);
    int k = 0;
    while (dq.size() < n && k < 400) begin cycle(); k++; end
    chk({tag, "_timeout"}, 64'(dq.size() >= n), 64'd1);
  endtask

  task automatic take_d(output beat_t d);
    d = '0;
    if (dq.size() > 0) d = dq.pop_front();
  endtask

  task automatic mul_case(input string tag, input int a, input int b, input int sh, input bit rnd,
                          input bit st, input int exp);
    beat_t d;
    set_cfg(1'b0, 1'b0, rnd, st, sh, 0);
    push_ab(uni(a), uni(b));
    wait_dq(1, tag);
    take_d(d);
    chk(tag, d, uni(exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t d, held, c;
    beat_t ja[$], jb[$];
    int n0, k;

    bus.ctrl = '0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {bus.flags.state, bus.flags.cnt, bus.flags.acc_valid, bus.flags.done}, '0);
    chk("rst_dvalid", bus.d_valid, 0);
    chk("rst_cready", bus.c_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.ctrl.enable = 1'b1;
    drive();

    // MUL directed with exact one-cycle latency
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    n0 = n_ab;
    push_ab(mk(1, -2, 3, 4), mk(5, 6, -7, 8));
    k = 0;
    while (n_ab == n0 && k < 20) begin cycle(); k++; end
    chk("mul_hs_seen", 64'(n_ab - n0), 64'd1);
    chk("mul_not_early", o_dv, 0);
    cycle();
    chk("mul_lat_valid", o_dv, 1);
    chk("mul_data", o_dd, mk(5, -12, -21, 32));
    chk("strb", bus.d_strb, 8'hFF);
    dq.delete();

    // Saturation and rounding corners
    mul_case("sat_on",    32767, 32767, 0, 1'b0, 1'b1, 32767);
    mul_case("sat_off",   32767, 32767, 0, 1'b0, 1'b0, 1);
    mul_case("sat_neg",  -32768, 32767, 0, 1'b0, 1'b1, -32768);
    mul_case("rnd_pos_r",     3,     1, 1, 1'b1, 1'b0, 2);
    mul_case("rnd_pos_t",     3,     1, 1, 1'b0, 1'b0, 1);
    mul_case("rnd_neg_r",    -3,     1, 1, 1'b1, 1'b0, -1);
    mul_case("rnd_neg_t",    -3,     1, 1, 1'b0, 1'b0, -2);

    // Random MUL streams with bubbles and backpressure
    for (int bt = 0; bt < 2; bt++) begin
      if (bt == 0) set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      else         set_cfg(1'b0, 1'b0, 1'b1, 1'b1, int'($urandom_range(1, 20)), 0);
      expq.delete();
      for (int i = 0; i < 10; i++) begin
        beat_t x, y;
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        qa.push_back(x); qb.push_back(y);
        expq.push_back(mul_exp(x, y));
      end
      k = 0;
      while (dq.size() < 10 && k < 400) begin
        d_rdy = 1'($urandom_range(0, 1)); src_on = 1'($urandom_range(0, 1));
        drive(); cycle(); k++;
      end
      d_rdy = 1'b1; src_on = 1'b1; drive();
      chk("mul_rand_timeout", 64'(dq.size() >= 10), 64'd1);
      for (int i = 0; i < 10; i++) begin
        take_d(d);
        chk("mul_rand", d, expq[i]);
      end
    end

    // DOT with preload: 10 + 4*(2*2) = 26
    set_cfg(1'b1, 1'b1, 1'b0, 1'b0, 0, 4);
    qc.push_back(uni(10));
    n0 = n_ab;
    for (int i = 0; i < 4; i++) push_ab(uni(2), uni(2));
    pulse_start();
    wait_dq(1, "dot_pre");
    take_d(d);
    chk("dot_pre_data", d, uni(26));
    chk("dot_pre_lat", 64'(first_dv_cyc - last_ab_cyc), 64'd2);
    chk("dot_pre_nab", 64'(n_ab - n0), 64'd4);
    cycle();
    chk("dot_done_pulse", o_done, 1);
    chk("dot_idle", o_state, 2'd0);
    cycle();
    chk("dot_done_drop", o_done, 0);

    // Over-supply and output stall
    ja.delete(); jb.delete();
    for (int i = 0; i < 5; i++) begin ja.push_back({$urandom, $urandom}); jb.push_back({$urandom, $urandom}); end
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 0, 3);
    n0 = n_ab;
    d_rdy = 1'b0;
    for (int i = 0; i < 5; i++) push_ab(ja[i], jb[i]);
    pulse_start();
    k = 0;
    while (!o_dv && k < 100) begin cycle(); k++; end
    chk("bp_reach_out", o_dv, 1);
    held = o_dd;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("bp_stable", {o_dv, o_dd}, {1'b1, held});
    end
    chk("bp_nab", 64'(n_ab - n0), 64'd3);
    d_rdy = 1'b1; drive();
    wait_dq(1, "bp");
    take_d(d);
    chk("bp_data", d, dot_exp(1'b0, '0, ja, jb, 0, 3));
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 0, 2);
    pulse_start();
    wait_dq(1, "bp_next");
    take_d(d);
    chk("bp_next_data", d, dot_exp(1'b0, '0, ja, jb, 3, 2));
    chk("bp_next_nab", 64'(n_ab - n0), 64'd5);

    // Clear while accumulating, then a fresh rounded/saturated job
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 0, 4);
    n0 = n_ab;
    push_ab(uni(100), uni(100)); push_ab(uni(100), uni(100));
    pulse_start();
    k = 0;
    while (n_ab - n0 < 2 && k < 50) begin cycle(); k++; end
    cycle(); cycle();
    chk("clr_in_acc", o_state, 2'd2);
    bus.ctrl.clear = 1'b1;
    cycle();
    bus.ctrl.clear = 1'b0;
    cycle();
    chk("clr_flags", {o_state, o_cnt, o_accv, o_done}, '0);
    chk("clr_dvalid", o_dv, 0);
    ja.delete(); jb.delete();
    c = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin ja.push_back({$urandom, $urandom}); jb.push_back({$urandom, $urandom}); end
    set_cfg(1'b1, 1'b1, 1'b1, 1'b1, 2, 3);
    qc.push_back(c);
    for (int i = 0; i < 3; i++) push_ab(ja[i], jb[i]);
    pulse_start();
    wait_dq(1, "clr_next");
    take_d(d);
    chk("clr_next_data", d, dot_exp(1'b1, c, ja, jb, 0, 3));

    // len = 0: preload passes straight through, a/b left alone
    set_cfg(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    n0 = n_ab;
    qc.push_back(uni(7));
    push_ab(uni(9), uni(9));
    pulse_start();
    wait_dq(1, "len0_c");
    take_d(d);
    chk("len0_c_data", d, uni(7));
    chk("len0_c_nab", 64'(n_ab - n0), 64'd0);
    set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    pulse_start();
    wait_dq(1, "len0_z");
    take_d(d);
    chk("len0_z_data", d, '0);
    chk("len0_z_nab", 64'(n_ab - n0), 64'd0);
    qa.delete(); qb.delete(); drive();
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
